// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: read-side consumer for the async FIFO, running only in the FIFO
// read clock domain. It pops DATA_WIDTH-bit entries and packs WORD_BYTES of them,
// little-endian, into one wide word. The word is presented on a valid/ready stream.
// A flush request emits a partial word. Optional idle-timeout auto-flush is
// compiled in when FIFO_RD_PACK_TIMEOUT_EN is defined.
module fifo_rd_packer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned WORD_BYTES = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                             rd_clk,
  input  logic                             rd_rst_n,
  input  logic                             fifo_empty,
  input  logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             rd_en,
  input  logic                             flush,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WORD_BYTES*DATA_WIDTH-1:0] out_data,
  output logic [WORD_BYTES-1:0]            out_keep
);

  localparam int unsigned LaneW = $clog2(WORD_BYTES);
  localparam int unsigned CntW  = LaneW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(WORD_BYTES);

  // Lane count must be a power of two (at least two) and the timeout at least one cycle.
  if ((WORD_BYTES < 2) || ((WORD_BYTES & (WORD_BYTES - 1)) != 0) || (TIMEOUT < 1)) begin : gBadParams
    $error("fifo_rd_packer: illegal parameter combination");
  end

  logic [WORD_BYTES-1:0][DATA_WIDTH-1:0] asm_q, asm_d;
  logic [CntW-1:0]                       cnt_q, cnt_d;
  logic                                  pend_q, pend_d;
  logic                                  flushPend_q, flushPend_d;
  logic                                  outValid_q, outValid_d;
  logic [WORD_BYTES*DATA_WIDTH-1:0]      outData_q, outData_d;
  logic [WORD_BYTES-1:0]                 outKeep_q, outKeep_d;

  logic                                  slotFree;
  logic [CntW-1:0]                       occ;
  logic [CntW-1:0]                       cntLanded;
  logic                                  popIssue;
  logic                                  fullEmit;
  logic                                  partialEmit;
  logic                                  timeoutHit;
  logic [WORD_BYTES-1:0]                 partKeep;
  logic [WORD_BYTES*DATA_WIDTH-1:0]      partData;

  // The output slot can take a new word when it is empty or being drained right now.
  assign slotFree = !outValid_q || out_ready;
  assign occ      = cnt_q + CntW'(pend_q);

  // A pop is allowed while the word has room counting the in-flight byte. It is
  // also allowed when that in-flight byte completes the word and the word can
  // leave this cycle, so a continuous stream has no bubble between words.
  assign popIssue = rd_rst_n && !fifo_empty && !flushPend_q &&
                    ((occ < FullCnt) || ((occ == FullCnt) && pend_q && slotFree));
  assign rd_en    = popIssue;

`ifdef FIFO_RD_PACK_TIMEOUT_EN
  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);
  localparam logic [IdleW-1:0] IdleMax = IdleW'(TIMEOUT);

  logic [IdleW-1:0] idle_q, idle_d;

  assign timeoutHit = (idle_q == IdleMax);

  // Count cycles where a partial word sits untouched; saturate at the threshold.
  always_comb begin
    idle_d = idle_q;
    if (pend_q || fullEmit || partialEmit) begin
      idle_d = '0;
    end else if ((cnt_q != '0) && !popIssue && (idle_q != IdleMax)) begin
      idle_d = idle_q + 1'b1;
    end
  end

  // Idle counter register.
  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  assign timeoutHit = 1'b0;
`endif

  // Build the masked partial word: lanes at or above cnt read as zero.
  always_comb begin
    partKeep = '0;
    partData = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      partKeep[i] = (CntW'(i) < cnt_q);
      partData[i*DATA_WIDTH +: DATA_WIDTH] = partKeep[i] ? asm_q[i] : '0;
    end
  end

  // Land the in-flight byte, then decide whether a full or a partial word leaves.
  always_comb begin
    asm_d     = asm_q;
    cntLanded = cnt_q;
    if (pend_q) begin
      asm_d[cnt_q[LaneW-1:0]] = rd_data;
      cntLanded               = cnt_q + 1'b1;
    end
    fullEmit    = (cntLanded == FullCnt) && slotFree;
    partialEmit = flushPend_q && !pend_q && slotFree &&
                  (cnt_q != '0) && (cnt_q != FullCnt);
  end

  // Next state for the counters, the flush request and the output register.
  always_comb begin
    cnt_d       = cntLanded;
    pend_d      = popIssue;
    flushPend_d = 1'b0;
    outValid_d  = outValid_q;
    outData_d   = outData_q;
    outKeep_d   = outKeep_q;

    if (fullEmit) begin
      outValid_d = 1'b1;
      outData_d  = asm_d;
      outKeep_d  = '1;
      cnt_d      = '0;
    end else if (partialEmit) begin
      outValid_d = 1'b1;
      outData_d  = partData;
      outKeep_d  = partKeep;
      cnt_d      = '0;
    end else if (out_ready) begin
      outValid_d = 1'b0;
    end

    // Any emission satisfies an outstanding flush, so a flush that meets a
    // completing word never produces an extra word behind it.
    if (fullEmit || partialEmit) begin
      flushPend_d = 1'b0;
    end else if (flushPend_q) begin
      flushPend_d = (cnt_q != '0) || pend_q;
    end else if ((flush || timeoutHit) && (occ != '0)) begin
      flushPend_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      asm_q       <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      flushPend_q <= 1'b0;
      outValid_q  <= 1'b0;
      outData_q   <= '0;
      outKeep_q   <= '0;
    end else begin
      asm_q       <= asm_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      flushPend_q <= flushPend_d;
      outValid_q  <= outValid_d;
      outData_q   <= outData_d;
      outKeep_q   <= outKeep_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign out_keep  = outKeep_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Testbench for fifo_rd_packer: a FIFO model feeds the packer. Accepted output
// words are captured and compared against words built from the pushed bytes.
module tb_fifo_rd_packer;

  localparam int DW = 8;
  localparam int WB = 4;
  localparam int TO = 16;

  logic          rd_clk = 1'b0;
  logic          rd_rst_n;
  logic          fifo_empty;
  logic [DW-1:0] rd_data = '0;
  logic          rd_en;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [WB*DW-1:0] out_data;
  logic [WB-1:0] out_keep;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:1023];
  int         wrPtr = 0;
  int         rdPtr = 0;
  logic       stall = 1'b0;
  int         popCount = 0;

  logic [31:0] gotData [$];
  logic [3:0]  gotKeep [$];

  fifo_rd_packer #(.DATA_WIDTH(DW), .WORD_BYTES(WB), .TIMEOUT(TO)) dut (
    .rd_clk    (rd_clk),
    .rd_rst_n  (rd_rst_n),
    .fifo_empty(fifo_empty),
    .rd_data   (rd_data),
    .rd_en     (rd_en),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_keep  (out_keep)
  );

  // Free-running read clock.
  always #5 rd_clk = ~rd_clk;

  assign fifo_empty = (wrPtr == rdPtr) || stall;

  // FIFO read side: data appears the cycle after a pop, and reset empties the FIFO.
  always @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      rdPtr <= wrPtr;
    end else if (rd_en && !fifo_empty) begin
      rd_data  <= mem[rdPtr];
      rdPtr    <= rdPtr + 1;
      popCount <= popCount + 1;
    end
  end

  // Capture every word the downstream side accepts.
  always @(posedge rd_clk) begin
    if (rd_rst_n && out_valid && out_ready) begin
      gotData.push_back(out_data);
      gotKeep.push_back(out_keep);
    end
  end

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic pushByte(input logic [7:0] b);
    mem[wrPtr] = b;
    wrPtr = wrPtr + 1;
  endtask

  task automatic waitWords(input int target, input int limit);
    for (int c = 0; c < limit && gotData.size() < target; c++) tick();
  endtask

  task automatic test_reset();
    rd_rst_n  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    stall     = 1'b0;
    tick();
    for (int c = 0; c < 3; c++) begin
      pushByte(8'h50 + 8'(c));
      #1;
      checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en cycle %0d: got %b expected 0", c, rd_en); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid cycle %0d: got %b expected 0", c, out_valid); end
      checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data cycle %0d: got %h expected 0", c, out_data); end
      checks++; if (out_keep !== 4'h0) begin errors++; $display("FAIL reset_out_keep cycle %0d: got %h expected 0", c, out_keep); end
      tick();
    end
    rd_rst_n = 1'b1;
  endtask

  task automatic test_streaming();
    int base;
    int p0;
    logic [11:0] enSeen;
    out_ready = 1'b1;
    base = gotData.size();
    p0 = popCount;
    for (int b = 1; b <= 8; b++) pushByte(8'(b));
    #1;
    for (int c = 0; c < 12; c++) begin
      enSeen[c] = rd_en;
      tick();
    end
    checks++; if (enSeen !== 12'h0FF) begin errors++; $display("FAIL stream_rd_en_pattern: got %h expected 0ff", enSeen); end
    checks++; if (popCount - p0 != 8) begin errors++; $display("FAIL stream_pops: got %0d expected 8", popCount - p0); end
    waitWords(base + 2, 20);
    checks++; if (gotData.size() != base + 2) begin errors++; $display("FAIL stream_word_count: got %0d expected %0d", gotData.size() - base, 2); end
    if (gotData.size() >= base + 2) begin
      checks++; if (gotData[base] !== 32'h04030201) begin errors++; $display("FAIL stream_word0: got %h expected 04030201", gotData[base]); end
      checks++; if (gotData[base+1] !== 32'h08070605) begin errors++; $display("FAIL stream_word1: got %h expected 08070605", gotData[base+1]); end
      checks++; if (gotKeep[base] !== 4'hF || gotKeep[base+1] !== 4'hF) begin errors++; $display("FAIL stream_keep: got %h/%h expected f/f", gotKeep[base], gotKeep[base+1]); end
    end
  endtask

  task automatic test_backpressure();
    int base;
    int p0;
    int unstable;
    out_ready = 1'b0;
    base = gotData.size();
    p0 = popCount;
    unstable = 0;
    for (int b = 1; b <= 12; b++) pushByte(8'(b));
    #1;
    for (int c = 0; c < 20; c++) begin
      if (c >= 6 && (out_valid !== 1'b1 || out_data !== 32'h04030201 || out_keep !== 4'hF)) unstable++;
      tick();
    end
    checks++; if (unstable != 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", unstable); end
    checks++; if (popCount - p0 != 8) begin errors++; $display("FAIL bp_pops: got %0d expected 8", popCount - p0); end
    checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL bp_rd_en_stalled: got %b expected 0", rd_en); end
    checks++; if (gotData.size() != base) begin errors++; $display("FAIL bp_no_accept: got %0d words expected 0", gotData.size() - base); end
    out_ready = 1'b1;
    waitWords(base + 3, 40);
    checks++; if (gotData.size() != base + 3) begin errors++; $display("FAIL bp_word_count: got %0d expected 3", gotData.size() - base); end
    if (gotData.size() >= base + 3) begin
      checks++; if (gotData[base] !== 32'h04030201) begin errors++; $display("FAIL bp_word0: got %h expected 04030201", gotData[base]); end
      checks++; if (gotData[base+1] !== 32'h08070605) begin errors++; $display("FAIL bp_word1: got %h expected 08070605", gotData[base+1]); end
      checks++; if (gotData[base+2] !== 32'h0C0B0A09) begin errors++; $display("FAIL bp_word2: got %h expected 0c0b0a09", gotData[base+2]); end
    end
  endtask

  task automatic test_flush();
    int base;
    out_ready = 1'b1;
    base = gotData.size();
    pushByte(8'hAA); pushByte(8'hBB); pushByte(8'hCC);
    repeat (6) tick();
    checks++; if (gotData.size() != base) begin errors++; $display("FAIL flush_no_early_word: got %0d words expected 0", gotData.size() - base); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    pushByte(8'hDD);
    #1;
    checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL flush_pop_blocked: got %b expected 0", rd_en); end
    tick();
    checks++; if (rd_en !== 1'b1) begin errors++; $display("FAIL flush_pop_resumes: got %b expected 1", rd_en); end
    waitWords(base + 1, 10);
    checks++; if (gotData.size() != base + 1) begin errors++; $display("FAIL flush_word_count: got %0d expected 1", gotData.size() - base); end
    if (gotData.size() >= base + 1) begin
      checks++; if (gotData[base] !== 32'h00CCBBAA) begin errors++; $display("FAIL flush_word: got %h expected 00ccbbaa", gotData[base]); end
      checks++; if (gotKeep[base] !== 4'h7) begin errors++; $display("FAIL flush_keep: got %h expected 7", gotKeep[base]); end
    end
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    waitWords(base + 2, 10);
    checks++; if (gotData.size() != base + 2) begin errors++; $display("FAIL flush_single_count: got %0d expected 2", gotData.size() - base); end
    if (gotData.size() >= base + 2) begin
      checks++; if (gotData[base+1] !== 32'h000000DD || gotKeep[base+1] !== 4'h1) begin errors++; $display("FAIL flush_single: got %h/%h expected 000000dd/1", gotData[base+1], gotKeep[base+1]); end
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (5) tick();
    checks++; if (gotData.size() != base + 2) begin errors++; $display("FAIL flush_empty_ignored: got %0d words expected 2", gotData.size() - base); end
    pushByte(8'hE1); pushByte(8'hE2); pushByte(8'hE3); pushByte(8'hE4);
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (8) tick();
    checks++; if (gotData.size() != base + 3) begin errors++; $display("FAIL flush_full_count: got %0d words expected 3", gotData.size() - base); end
    if (gotData.size() >= base + 3) begin
      checks++; if (gotData[base+2] !== 32'hE4E3E2E1 || gotKeep[base+2] !== 4'hF) begin errors++; $display("FAIL flush_full_word: got %h/%h expected e4e3e2e1/f", gotData[base+2], gotKeep[base+2]); end
    end
  endtask

  task automatic test_timeout();
    int base;
    out_ready = 1'b1;
    base = gotData.size();
    pushByte(8'h11); pushByte(8'h22);
`ifdef FIFO_RD_PACK_TIMEOUT_EN
    begin
      int cyc;
      cyc = 0;
      while (gotData.size() < base + 1 && cyc < 60) begin
        tick();
        cyc++;
      end
      checks++; if (gotData.size() != base + 1) begin errors++; $display("FAIL timeout_word_count: got %0d expected 1", gotData.size() - base); end
      checks++; if (cyc < TO) begin errors++; $display("FAIL timeout_latency: got %0d cycles expected at least %0d", cyc, TO); end
    end
`else
    repeat (100) tick();
    checks++; if (gotData.size() != base) begin errors++; $display("FAIL timeout_absent: got %0d words expected 0", gotData.size() - base); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    waitWords(base + 1, 10);
`endif
    if (gotData.size() >= base + 1) begin
      checks++; if (gotData[base] !== 32'h00002211) begin errors++; $display("FAIL timeout_word: got %h expected 00002211", gotData[base]); end
      checks++; if (gotKeep[base] !== 4'h3) begin errors++; $display("FAIL timeout_keep: got %h expected 3", gotKeep[base]); end
    end
  endtask

  task automatic test_reset_mid_word();
    int base;
    out_ready = 1'b1;
    base = gotData.size();
    pushByte(8'hE0); pushByte(8'hE1);
    repeat (4) tick();
    rd_rst_n = 1'b0;
    tick();
    rd_rst_n = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid: got %b expected 0", out_valid); end
    for (int b = 5; b <= 8; b++) pushByte(8'(b));
    repeat (15) tick();
    checks++; if (gotData.size() != base + 1) begin errors++; $display("FAIL midreset_word_count: got %0d expected 1", gotData.size() - base); end
    if (gotData.size() >= base + 1) begin
      checks++; if (gotData[base] !== 32'h08070605 || gotKeep[base] !== 4'hF) begin errors++; $display("FAIL midreset_word: got %h/%h expected 08070605/f", gotData[base], gotKeep[base]); end
    end
  endtask

  task automatic test_random();
    int base;
    int pushed;
    int holdErr;
    int cyc;
    logic prevHold;
    logic [31:0] prevData;
    logic [3:0] prevKeep;
    logic [7:0] modelBytes [$];
    logic [31:0] expWord;
    logic [7:0] b;
    base = gotData.size();
    pushed = 0;
    holdErr = 0;
    cyc = 0;
    prevHold = 1'b0;
    prevData = '0;
    prevKeep = '0;
    while (gotData.size() < base + 75 && cyc < 4000) begin
      if (pushed < 300 && $urandom_range(0, 9) < 7) begin
        b = 8'($urandom);
        pushByte(b);
        modelBytes.push_back(b);
        pushed++;
      end
      stall     = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      #1;
      if (prevHold && (out_valid !== 1'b1 || out_data !== prevData || out_keep !== prevKeep)) holdErr++;
      prevHold = out_valid && !out_ready;
      prevData = out_data;
      prevKeep = out_keep;
      tick();
      cyc++;
    end
    stall = 1'b0;
    out_ready = 1'b1;
    checks++; if (gotData.size() != base + 75) begin errors++; $display("FAIL random_word_count: got %0d expected 75", gotData.size() - base); end
    checks++; if (holdErr != 0) begin errors++; $display("FAIL random_output_hold: got %0d violations expected 0", holdErr); end
    for (int i = 0; i < 75 && base + i < gotData.size(); i++) begin
      for (int k = 0; k < 4; k++) expWord[k*8 +: 8] = modelBytes[4*i + k];
      checks++; if (gotData[base+i] !== expWord || gotKeep[base+i] !== 4'hF) begin errors++; $display("FAIL random_word%0d: got %h/%h expected %h/f", i, gotData[base+i], gotKeep[base+i], expWord); end
    end
  endtask

  // Run each scenario in order, then report.
  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_timeout();
    test_reset_mid_word();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side consumer for the project's async FIFO. It lives entirely in the FIFO's read clock domain. It pops DATA_WIDTH-bit entries through the FIFO's rd_en/fifo_empty/rd_data port and packs WORD_BYTES consecutive entries, little-endian, into one wide word. The word is presented on a valid/ready output stream to the downstream datapath. Partial words are emitted on request via a flush input, or on idle timeout if configured.

## Interface
- DATA_WIDTH, 8: width of one FIFO entry (one lane).
- WORD_BYTES, 4: lanes per output word; power of two, ≥2.
- TIMEOUT, 16: idle cycles before auto-flush; used only with the timeout feature compiled in; ≥1.

Ports:
- rd_clk  in  1  sole clock (FIFO read clock).
- rd_rst_n  in  1  reset; synchronous, active-low.
- fifo_empty  in  1  FIFO empty flag.
- rd_data  in  DATA_WIDTH  FIFO read data; valid the cycle after a pop.
- rd_en  out  1  FIFO pop request; a pop occurs when rd_en && !fifo_empty at a rd_clk edge.
- flush  in  1  request emission of the current partial word.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accept.
- out_data  out  WORD_BYTES*DATA_WIDTH  packed word; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_keep  out  WORD_BYTES  lane-valid mask; bit i set ⇒ lane i holds real data.

## Operation
- Internal state:
  - asm: assembly register, WORD_BYTES lanes.
  - cnt: lanes filled, 0..WORD_BYTES.
  - pend: 1 if a pop was issued last cycle and its data lands this cycle.
  - flush_pend.
  - Output register: out_valid, out_data, out_keep.
- slot_free = !out_valid || out_ready.
- Landing byte: when pend=1, rd_data is written to lane cnt, and cnt increments.
- Word completion: when cnt reaches WORD_BYTES (including via the landing byte):
  - If slot_free: asm moves to the output register with out_keep = all ones, and cnt = 0 in the same cycle.
  - Otherwise cnt holds WORD_BYTES, asm is frozen, and the transfer happens on the first slot_free cycle.
- Pop rule: rd_en = rd_rst_n && !fifo_empty && !flush_pend && (occ < WORD_BYTES || (occ == WORD_BYTES && pend && slot_free)), where occ = cnt + pend.
  - This gives a sustained rate of one entry per cycle with no per-word bubble.
  - Bytes are never lost or reordered.
- Flush:
  - flush=1 with (cnt+pend) > 0 sets flush_pend.
  - While flush_pend, no new pops are issued; the in-flight byte still lands.
  - Once pend=0 and slot_free, the partial word is emitted:
    - out_keep = (1<<cnt)-1.
    - Unfilled lanes are zero.
    - cnt = 0 and flush_pend clears.
  - flush with (cnt+pend)=0 is ignored.
  - flush coinciding with a full word: the full word is emitted normally and no empty word follows.
- Output hold: while out_valid && !out_ready, out_data and out_keep are stable.

## Timing
- Reset (rd_rst_n low at an edge):
  - out_valid=0, out_data=0, out_keep=0, cnt=0, pend=0, flush_pend=0, idle counter=0.
  - rd_en is combinationally 0 while rd_rst_n is low.
- Reset mid-operation discards asm, any in-flight byte, and any unaccepted output word. The FIFO read pointer shares rd_rst_n.
- Latency: pop at edge N → byte in asm at edge N+1.
  - The word is valid on out_valid after the edge at which its last byte lands.
  - Minimum latency from the first pop to out_valid is WORD_BYTES cycles.
- Flush latency: at most 2 cycles after flush when the slot is free (1 for the in-flight byte, 1 to emit).
- The output register is a single stage; out_ready has no combinational path to out_valid/out_data. rd_en depends combinationally on out_ready.

## Configuration
- FIFO_RD_PACK_TIMEOUT_EN defined:
  - An idle counter increments each cycle that cnt>0, pend=0 and no pop is issued.
  - It clears on any landing byte or word emission.
  - When it reaches TIMEOUT, the block behaves as if flush were asserted.
- Not defined:
  - No counter is built and TIMEOUT is unused.
  - Partial words leave only via flush.

## Test plan
- Reset: hold rd_rst_n=0 for 3 cycles with the FIFO non-empty → rd_en=0, out_valid=0, out_data=0, out_keep=0 throughout.
- Streaming: 8 entries 0x01..0x08, out_ready=1 → rd_en high 8 consecutive cycles; words 0x04030201 then 0x08070605, keep 0xF.
- Backpressure: 12 entries, out_ready=0 →
  - out_data holds 0x04030201 stable.
  - rd_en drops after 4 more entries.
  - After out_ready=1, words 0x04030201, 0x08070605, 0x0C0B0A09 arrive in order with no loss.
- Flush: entries 0xAA, 0xBB, 0xCC, then one-cycle flush → single word 0x00CCBBAA, keep 0x7; no pop occurs while flush_pend is set.
- Timeout: entries 0x11, 0x22, then FIFO empty →
  - With macro: after 16 idle cycles, word 0x00002211, keep 0x3.
  - Without macro: no output after 100 cycles.
- Reset mid-word: 2 entries popped, reset pulse, then entries 0x05..0x08 → only word 0x08070605, keep 0xF.
